// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state codes, control-flow opcodes
// and pc_block source-select codes.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } stateT;

  localparam logic [3:0] OP_J     = 4'h8;
  localparam logic [3:0] OP_JR    = 4'h9;
  localparam logic [3:0] OP_BR    = 4'hA;
  localparam logic [3:0] OP_JM    = 4'hB;
  localparam logic [3:0] OP_JPM   = 4'hC;
  localparam logic [3:0] OP_JCMP  = 4'hD;
  localparam logic [3:0] OP_JCMPL = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Source-select encodings shared with pc_block
  localparam logic [3:0] PC2       = 4'd0;
  localparam logic [3:0] IMMPC     = 4'd1;
  localparam logic [3:0] IMMADDR   = 4'd2;
  localparam logic [3:0] RA        = 4'd3;
  localparam logic [3:0] MARY      = 4'd4;
  localparam logic [3:0] PCMARY    = 4'd5;
  localparam logic [3:0] JCMPIMM   = 4'd6;
  localparam logic [3:0] JCMPIMMLS = 4'd7;

endpackage

// File: rtl/pc_src_decode.sv
// Maps the latched opcode to the PC controls applied in the execute state.
module pc_src_decode
  import pc_sequencer_pkg::*;
(
  input  logic [3:0] opReg,
  output logic [3:0] pcSrc,
  output logic       pcWrite,
  output logic       jcmp,
  output logic       isHalt
);

  always_comb begin
    pcSrc   = PC2;
    pcWrite = 1'b0;
    jcmp    = 1'b0;
    isHalt  = 1'b0;
    unique case (opReg)
      OP_J:     begin pcSrc = IMMADDR;   pcWrite = 1'b1; end
      OP_JR:    begin pcSrc = RA;        pcWrite = 1'b1; end
      OP_BR:    begin pcSrc = IMMPC;     pcWrite = 1'b1; end
      OP_JM:    begin pcSrc = MARY;      pcWrite = 1'b1; end
      OP_JPM:   begin pcSrc = PCMARY;    pcWrite = 1'b1; end
      OP_JCMP:  begin pcSrc = JCMPIMM;   pcWrite = 1'b1; jcmp = 1'b1; end
      OP_JCMPL: begin pcSrc = JCMPIMMLS; pcWrite = 1'b1; jcmp = 1'b1; end
      OP_HALT:  isHalt = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/execute control FSM driving pc_block, with memory
// ready handshake, execute stall and a retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic               memReady,
  input  logic               stall,
  output logic               memReq,
  output logic               irWrite,
  output logic               pcWrite,
  output logic [3:0]         pcSrc,
  output logic               jcmp,
  output logic               pcReset,
  output logic               halted,
  output logic [COUNT_W-1:0] instrCount,
  output logic [2:0]         state
);

  stateT      curState, nextState;
  logic [3:0] opReg;
  logic [3:0] decSrc;
  logic       decWrite, decJcmp, decHalt;
  logic       retire;

  pc_src_decode uDecode (
    .opReg   (opReg),
    .pcSrc   (decSrc),
    .pcWrite (decWrite),
    .jcmp    (decJcmp),
    .isHalt  (decHalt)
  );

  assign retire = (curState == ST_EXEC) && !stall && !decHalt;
  assign state  = curState;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) curState <= ST_RST;
    else       curState <= nextState;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opReg      <= '0;
      instrCount <= '0;
    end else begin
      if (curState == ST_DECODE) opReg <= opcode;
      if (retire) instrCount <= instrCount + COUNT_W'(1);
    end
  end

  always_comb begin
    nextState = curState;
    unique case (curState)
      ST_RST:    nextState = ST_FETCH;
      ST_FETCH:  nextState = memReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: nextState = ST_EXEC;
      // stall takes priority over a pending halt
      ST_EXEC:   if (!stall) nextState = decHalt ? ST_HALT : ST_FETCH;
      ST_HALT:   nextState = ST_HALT;
      default:   nextState = ST_RST;
    endcase
  end

  always_comb begin
    memReq  = 1'b0;
    irWrite = 1'b0;
    pcWrite = 1'b0;
    pcSrc   = PC2;
    jcmp    = 1'b0;
    pcReset = 1'b0;
    halted  = 1'b0;
    unique case (curState)
      ST_RST:   pcReset = 1'b1;
      ST_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pcWrite = decWrite;
          pcSrc   = decSrc;
          jcmp    = decJcmp;
        end
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

endmodule
